// File: rtl/set_field_sequencer.sv
// Edit-mode sequencer for the clock/calendar field counters: one-hot field select plus aum/dism step pulses.
// Optional hold-to-repeat stepping is built when SET_FIELD_AUTO_REPEAT_EN is defined.
module set_field_sequencer #(
  parameter int unsigned N_FIELDS       = 6,
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned REPEAT_CYCLES  = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_edit,
  input  logic                btn_right,
  input  logic                btn_left,
  input  logic                btn_up,
  input  logic                btn_down,
  output logic                edit_active,
  output logic [SEL_W-1:0]    field_sel,
  output logic [N_FIELDS-1:0] en_field,
  output logic                aum,
  output logic                dism
);

  typedef enum logic {IDLE, EDIT} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_FIELDS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t               state, nxt_state;
  logic [4:0]           btn_s, btn_q, rise;
  logic [CNT_W-1:0]     tmo_cnt, nxt_tmo;
  logic [SEL_W-1:0]     nxt_sel;
  logic [N_FIELDS-1:0]  nxt_en;
  logic                 nxt_aum, nxt_dism;
  logic                 edit_go, nav_r, nav_l, nav, step_up, step_dn;
  logic                 rep_up, rep_dn;

  // Buttons are captured in btn_s first, so rise is seen one cycle after the press
  // and the resulting outputs appear one cycle later still.
  always_comb begin
    rise    = btn_s & ~btn_q;
    edit_go = (state == EDIT) && !rise[0];
    nav_r   = edit_go & rise[1] & ~rise[2];
    nav_l   = edit_go & rise[2] & ~rise[1];
    nav     = nav_r | nav_l;
    step_up = edit_go & ~nav & rise[3] & ~rise[4];
    step_dn = edit_go & ~nav & rise[4] & ~rise[3];
  end

`ifdef SET_FIELD_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             rep_on, rep_dir_up, rep_first, still_held, rep_fire;
  logic [CNT_W-1:0] hold_cnt;

  always_comb begin
    still_held = rep_dir_up ? (btn_s[3] & ~btn_s[4]) : (btn_s[4] & ~btn_s[3]);
    rep_fire   = edit_go & ~nav & rep_on & still_held &
                 (hold_cnt == (rep_first ? HOLD_LAST : REP_LAST));
    rep_up     = rep_fire & rep_dir_up;
    rep_dn     = rep_fire & ~rep_dir_up;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_on     <= 1'b0;
      rep_dir_up <= 1'b0;
      rep_first  <= 1'b0;
      hold_cnt   <= '0;
    end else if (step_up || step_dn) begin
      rep_on     <= btn_s[3] ^ btn_s[4];
      rep_dir_up <= step_up;
      rep_first  <= 1'b1;
      hold_cnt   <= '0;
    end else if (edit_go && !nav && rep_on && still_held) begin
      if (rep_fire) begin
        hold_cnt  <= '0;
        rep_first <= 1'b0;
      end else begin
        hold_cnt  <= hold_cnt + CNT_W'(1);
      end
    end else begin
      rep_on   <= 1'b0;
      hold_cnt <= '0;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_sel   = field_sel;
    nxt_tmo   = tmo_cnt;
    nxt_aum   = 1'b0;
    nxt_dism  = 1'b0;
    case (state)
      IDLE: begin
        nxt_tmo = '0;
        if (rise[0]) begin
          nxt_state = EDIT;
          nxt_sel   = '0;
        end
      end
      EDIT: begin
        if (rise[0]) begin
          nxt_state = IDLE;
          nxt_tmo   = '0;
        end else begin
          if (nav_r)
            nxt_sel = (field_sel == LAST_SEL) ? '0 : field_sel + SEL_W'(1);
          else if (nav_l)
            nxt_sel = (field_sel == '0) ? LAST_SEL : field_sel - SEL_W'(1);
          nxt_aum  = step_up | rep_up;
          nxt_dism = step_dn | rep_dn;
          if (nav || nxt_aum || nxt_dism)
            nxt_tmo = '0;
          else if (TMO_EN && tmo_cnt == TMO_LAST) begin
            nxt_state = IDLE;
            nxt_tmo   = '0;
          end else if (tmo_cnt != '1)
            nxt_tmo = tmo_cnt + CNT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
    for (int unsigned i = 0; i < N_FIELDS; i++)
      nxt_en[i] = (nxt_state == EDIT) && (nxt_sel == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      btn_s       <= '0;
      btn_q       <= '0;
      tmo_cnt     <= '0;
      field_sel   <= '0;
      en_field    <= '0;
      edit_active <= 1'b0;
      aum         <= 1'b0;
      dism        <= 1'b0;
    end else begin
      btn_s       <= {btn_down, btn_up, btn_left, btn_right, btn_edit};
      btn_q       <= btn_s;
      state       <= nxt_state;
      tmo_cnt     <= nxt_tmo;
      field_sel   <= nxt_sel;
      en_field    <= nxt_en;
      edit_active <= (nxt_state == EDIT);
      aum         <= nxt_aum;
      dism        <= nxt_dism;
    end
  end

endmodule

// File: doc/set_field_sequencer.md
Name: set_field_sequencer

Overview:
- Edit-mode controller for the clock/calendar setting datapath. It sequences the per-field up/down counters (the wrap-around 0..12 style field counters) from front-panel buttons.
- Selects one field at a time through a one-hot enable bus.
- Converts button edges into single-cycle aum/dism step pulses, with an optional hold-to-repeat feature.
- Sits between the button debouncers and the bank of field counters.

Parameters:
- N_FIELDS, 6, number of editable field counters (2..8).
- SEL_W, 3, width of the field index; must hold N_FIELDS-1.
- CNT_W, 32, width of the internal timers.
- TIMEOUT_CYCLES, 1000000000, idle cycles in EDIT before automatic exit; 0 disables the timeout.
- HOLD_CYCLES, 50000000, cycles a step button must be held before the first repeat pulse.
- REPEAT_CYCLES, 10000000, period of repeat pulses after the first one.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (reset=0 resets the block on the next clk rising edge)
- btn_edit  in  1  debounced level; a rising edge toggles edit mode
- btn_right  in  1  debounced level; a rising edge selects the next field
- btn_left  in  1  debounced level; a rising edge selects the previous field
- btn_up  in  1  debounced level; a rising edge produces an increment step
- btn_down  in  1  debounced level; a rising edge produces a decrement step
- edit_active  out  1  high while in EDIT
- field_sel  out  SEL_W  index of the selected field
- en_field  out  N_FIELDS  one-hot enable to the field counters; all zero outside EDIT
- aum  out  1  one-cycle increment pulse, shared by all field counters
- dism  out  1  one-cycle decrement pulse, shared by all field counters

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge):
  - state IDLE; edit_active=0, field_sel=0, en_field=0, aum=0, dism=0.
  - All timers cleared.
  - Edge-detect history registers cleared to 0, so a button already high when reset releases counts as a rising edge.
  - Reset overrides any in-progress edit or repeat.
- Edge detection: rise_x = btn_x & ~btn_x_q, where btn_x_q is the value registered on the previous cycle. A press sampled at edge k takes effect at the outputs after edge k+1 (1-cycle latency).
- States: IDLE, EDIT.
  - IDLE -> EDIT on rise_edit: field_sel=0, timeout timer cleared.
  - EDIT -> IDLE on rise_edit, or when the timeout timer reaches TIMEOUT_CYCLES-1 (only if TIMEOUT_CYCLES != 0).
  - In IDLE every other button is ignored; aum and dism stay 0.
- Priority within one cycle in EDIT, highest first:
  1. rise_edit (exit; no step, no navigation).
  2. Navigation: rise_right alone gives field_sel+1, wrapping N_FIELDS-1 -> 0; rise_left alone gives field_sel-1, wrapping 0 -> N_FIELDS-1. rise_left and rise_right together: no change. When navigation occurs, any step in the same cycle is suppressed.
  3. Step: rise_up alone gives aum=1 for one cycle; rise_down alone gives dism=1 for one cycle; both together give neither.
- aum and dism are never high simultaneously.
- en_field[i] = edit_active & (field_sel == i). It changes in the same cycle as field_sel.
- Timeout timer:
  - Clears on any accepted navigation or step, including repeat pulses.
  - Otherwise increments in EDIT and saturates; held at 0 in IDLE.
- field_sel is retained in IDLE and reset to 0 on every entry into EDIT.

Optional Feature:
- Macro: SET_FIELD_AUTO_REPEAT_EN.
- Defined:
  - Hold timer starts at rise_up or rise_down, provided exactly one of btn_up/btn_down is high.
  - While that button stays high and the other stays low, an extra pulse on the same output (aum or dism) occurs HOLD_CYCLES cycles after the initial pulse, then every REPEAT_CYCLES.
  - The repeat stops immediately on release, on the other step button going high, on navigation, or on leaving EDIT.
  - Repeat pulses clear the timeout timer.
- Undefined: only edge-generated single pulses; the hold timer logic is not instantiated.

Test Plan:
Bench parameters: N_FIELDS=3, SEL_W=2, TIMEOUT_CYCLES=32, HOLD_CYCLES=8, REPEAT_CYCLES=4.
1. reset=0 for 2 cycles, then reset=1 with all buttons low -> all outputs 0; buttons pulsed in IDLE give aum=dism=0 and en_field=000.
2. Pulse btn_edit -> edit_active=1, field_sel=0, en_field=001. Press btn_up -> exactly one aum cycle, one cycle after the press. Press btn_down -> one dism cycle.
3. In EDIT press btn_right three times -> field_sel 1,2,0, en_field 010,100,001. Then press btn_left once -> field_sel=2 (wrap).
4. Raise btn_up and btn_down in the same cycle -> no pulse. Raise btn_right and btn_up in the same cycle -> field_sel advances, aum stays 0.
5. Enter EDIT and idle 32 cycles -> edit_active=0, en_field=000. A step press at cycle 20 restarts the count, so exit occurs 32 cycles after it.
6. With SET_FIELD_AUTO_REPEAT_EN defined, hold btn_up for 20 cycles -> aum pulses at relative cycles 1, 9, 13, 17 and stop on release. Without the macro -> single pulse at cycle 1.
